// File: rtl/seg_scanner.sv
// seg_scanner: time-multiplexed driver for an 8-digit 7-segment display.
// Each digit stays lit for REFRESH_DIV clocks. Captured data waits in a
// shadow register and is copied to the active register only at the frame
// boundary, so a frame is never shown half-old and half-new.
// Optional macro: LEADING_ZERO_BLANK_EN blanks leading zero digits 7..1.
module seg_scanner #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] value,
  input  logic [7:0]  digit_en,
  input  logic        load,
  output logic [4:0]  hex,
  output logic [7:0]  anodes,
  output logic        pending,
  output logic        frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] r_count;
  logic [2:0]    r_idx;
  logic [31:0]   r_act_val;
  logic [7:0]    r_act_en;
  logic [31:0]   r_sh_val;
  logic [7:0]    r_sh_en;
  logic          r_pending;
  logic          r_frame_done;
  logic [4:0]    r_hex;
  logic [7:0]    r_anodes;

  logic          w_tick;
  logic          w_wrap;
  logic [2:0]    w_idx_next;
  logic [31:0]   w_act_val_next;
  logic [7:0]    w_act_en_next;
  logic          w_show;
  logic [3:0]    w_nibble;
  logic [4:0]    w_hex_next;
  logic [7:0]    w_anodes_next;

  assign w_tick     = (r_count == LAST);
  assign w_wrap     = w_tick && (r_idx == 3'd7);
  assign w_idx_next = w_tick ? r_idx + 3'd1 : r_idx;

  // Next active contents: loaded on the wrap tick, from the input directly
  // when a load coincides with the wrap, otherwise from the shadow.
  always_comb begin
    w_act_val_next = r_act_val;
    w_act_en_next  = r_act_en;
    if (w_wrap) begin
      if (load) begin
        w_act_val_next = value;
        w_act_en_next  = digit_en;
      end else begin
        w_act_val_next = r_sh_val;
        w_act_en_next  = r_sh_en;
      end
    end
  end

  // Display code for the digit that will be lit after this edge; built from
  // next-state values so hex/anodes move in the same cycle as the index.
  always_comb begin
    w_nibble = w_act_val_next[{w_idx_next, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    w_show = (w_idx_next == 3'd0) ||
             ((w_act_val_next >> {w_idx_next, 2'b00}) != 32'd0);
`else
    w_show = 1'b1;
`endif
    w_hex_next    = {w_act_en_next[w_idx_next] & w_show, w_nibble};
    w_anodes_next = ~(8'd1 << w_idx_next);
  end

  // Prescaler and digit index.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
      r_idx   <= '0;
    end else begin
      r_count <= w_tick ? '0 : r_count + 1'b1;
      r_idx   <= w_idx_next;
    end
  end

  // Shadow/active double buffer and pending flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_act_val <= '0;
      r_act_en  <= '0;
      r_sh_val  <= '0;
      r_sh_en   <= '0;
      r_pending <= 1'b0;
    end else begin
      r_act_val <= w_act_val_next;
      r_act_en  <= w_act_en_next;
      if (load) begin
        r_sh_val <= value;
        r_sh_en  <= digit_en;
      end
      if (w_wrap)    r_pending <= 1'b0;
      else if (load) r_pending <= 1'b1;
    end
  end

  // Registered display outputs and frame pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hex        <= '0;
      r_anodes     <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_hex        <= w_hex_next;
      r_anodes     <= w_anodes_next;
      r_frame_done <= w_wrap;
    end
  end

  assign hex        = r_hex;
  assign anodes     = r_anodes;
  assign pending    = r_pending;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scanner.sv
// tb_seg_scanner: directed plus random stimulus against a cycle-count based
// reference model of the scanner (REFRESH_DIV = 4).
module tb_seg_scanner;

  localparam int DIV = 4;

  logic        clk;
  logic        rstn;
  logic [31:0] value;
  logic [7:0]  digit_en;
  logic        load;
  logic [4:0]  hex;
  logic [7:0]  anodes;
  logic        pending;
  logic        frame_done;

  int checks;
  int failures;

  // Reference state: edges since reset release plus buffer contents.
  int unsigned n;
  logic [31:0] m_act, m_sh;
  logic [7:0]  m_act_en, m_sh_en;
  logic        m_pend, m_fd;

  seg_scanner #(.REFRESH_DIV(DIV)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .value      (value),
    .digit_en   (digit_en),
    .load       (load),
    .hex        (hex),
    .anodes     (anodes),
    .pending    (pending),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned cur_idx();
    return (n / DIV) % 8;
  endfunction

  function automatic logic [4:0] exp_hex();
    int unsigned i;
    logic [3:0]  nib;
    logic        show;
    i    = cur_idx();
    nib  = 4'((m_act >> (4 * i)) & 32'hF);
    show = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
    show = (i == 0) || ((m_act >> (4 * i)) != 32'd0);
`endif
    return {m_act_en[i] & show, nib};
  endfunction

  function automatic logic [7:0] exp_anodes();
    logic [7:0] a;
    a = 8'hFF;
    a[cur_idx()] = 1'b0;
    return a;
  endfunction

  task automatic model_reset();
    n = 0; m_act = '0; m_sh = '0; m_act_en = '0; m_sh_en = '0;
    m_pend = 1'b0; m_fd = 1'b0;
  endtask

  // One clock: drive inputs, advance the model across the edge, check outputs.
  task automatic step(input logic ld, input logic [31:0] v, input logic [7:0] e);
    logic tick, wrap;
    load = ld; value = v; digit_en = e;
    @(posedge clk);
    tick = ((n % DIV) == DIV - 1);
    wrap = tick && (cur_idx() == 7);
    if (wrap && ld) begin
      m_act = v; m_act_en = e; m_sh = v; m_sh_en = e; m_pend = 1'b0;
    end else if (wrap) begin
      m_act = m_sh; m_act_en = m_sh_en; m_pend = 1'b0;
    end else if (ld) begin
      m_sh = v; m_sh_en = e; m_pend = 1'b1;
    end
    m_fd = wrap;
    n++;
    #1;
    load = 1'b0;
    chk("anodes", {24'd0, anodes}, {24'd0, exp_anodes()});
    chk("hex", {27'd0, hex}, {27'd0, exp_hex()});
    chk("pending", {31'd0, pending}, {31'd0, m_pend});
    chk("frame_done", {31'd0, frame_done}, {31'd0, m_fd});
  endtask

  task automatic idle(input int unsigned k);
    for (int unsigned i = 0; i < k; i++) step(1'b0, $urandom, 8'($urandom));
  endtask

  // Advance until the next edge is the 7->0 wrap tick.
  task automatic to_wrap();
    for (int unsigned i = 0; i < 32 && (n % 32) != 31; i++) idle(1);
  endtask

  task automatic to_digit(input int unsigned d);
    for (int unsigned i = 0; i < 32 && cur_idx() != d; i++) idle(1);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
  task automatic do_reset();
    #3;
    rstn = 1'b0;
    #1;
    chk("rst_anodes", {24'd0, anodes}, 32'hFF);
    chk("rst_hex", {27'd0, hex}, 32'h0);
    chk("rst_pending", {31'd0, pending}, 32'h0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_hold_anodes", {24'd0, anodes}, 32'hFF);
    rstn = 1'b1;
  endtask

  int fd_count;

  initial begin
    checks = 0; failures = 0;
    rstn = 1'b0; load = 1'b0; value = '0; digit_en = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("init_anodes", {24'd0, anodes}, 32'hFF);
    chk("init_hex", {27'd0, hex}, 32'h0);
    rstn = 1'b1;

    // Release: digit 0 on the first edge, digit 1 four cycles after release.
    idle(1);
    chk("rel_fe", {24'd0, anodes}, 32'hFE);
    idle(3);
    chk("rel_fd", {24'd0, anodes}, 32'hFD);

    // Full scan of 89ABCDEF.
    to_wrap();
    step(1'b1, 32'h89ABCDEF, 8'hFF);
    chk("scan_d0", {27'd0, hex}, 32'h1F);
    fd_count = 0;
    for (int unsigned i = 0; i < 64; i++) begin
      idle(1);
      if (frame_done) fd_count++;
    end
    chk("scan_fd_count", fd_count, 2);

    // Tearing: load at digit 3, applied only at the wrap.
    to_digit(3);
    step(1'b1, 32'h11111111, 8'hFF);
    chk("tear_pending", {31'd0, pending}, 32'h1);
    to_wrap();
    idle(1);
    chk("tear_hex", {27'd0, hex}, 32'h11);
    chk("tear_clear", {31'd0, pending}, 32'h0);

    // Load coincident with the wrap tick.
    to_wrap();
    step(1'b1, 32'h22222222, 8'hFF);
    chk("coin_pending", {31'd0, pending}, 32'h0);
    chk("coin_hex", {27'd0, hex}, 32'h12);
    idle(8);

    // Last write wins.
    to_digit(2);
    step(1'b1, 32'hDEADBEEF, 8'hAA);
    idle(3);
    step(1'b1, 32'h12345678, 8'h0F);
    to_wrap();
    idle(32);
    to_digit(5);
    chk("en_off", {31'd0, hex[4]}, 32'h0);

    // Leading zeros.
    to_wrap();
    step(1'b1, 32'h00000305, 8'hFF);
    idle(4);
    chk("lzb_d1", {27'd0, hex}, 32'h10);
    idle(28);

    // Reset discards a pending capture.
    to_digit(2);
    step(1'b1, 32'hFFFFFFFF, 8'hFF);
    do_reset();
    idle(40);
    chk("rst_discard_hex", {27'd0, hex}, 32'h0);

    // Random traffic with one reset in the middle.
    for (int unsigned i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      step(($urandom_range(0, 7) == 0), $urandom, 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scanner.md
SEG_SCANNER -- requirements
Module: seg_scanner

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clock cycles each digit stays lit (legal range >= 2).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port value  input  32  eight hex nibbles; nibble i = value[4i+3:4i] drives digit i; digit 0 is least significant.
REQ-005 SHALL have port digit_en  input  8  per-digit enable; 0 = digit dark.
REQ-006 SHALL have port load  input  1  one-cycle strobe capturing value and digit_en.
REQ-007 SHALL have port hex  output  5  {enable, nibble} code for the downstream 7-segment decoder.
REQ-008 SHALL have port anodes  output  8  digit select, active-low, one-hot-zero.
REQ-009 SHALL have port pending  output  1  captured data waiting for the frame boundary.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse at each digit 7->0 wrap.

Function
REQ-011 SHALL run a prescaler counting 0..REFRESH_DIV-1; tick = (count == REFRESH_DIV-1); count wraps to 0 on tick.
REQ-012 SHALL hold a 3-bit digit index, incremented on tick, wrapping 7->0.
REQ-013 SHALL, on load, copy value/digit_en into a shadow register and set pending, whatever the index.
REQ-014 SHALL transfer shadow to the active register only on the tick that wraps index 7->0 and clear pending then; no mid-frame tearing.
REQ-015 SHALL, when load and the wrap tick coincide, write value/digit_en straight into active and shadow, leaving pending = 0.
REQ-016 SHALL, when load repeats before the wrap, keep only the latest capture (last write wins).
REQ-017 SHALL assert frame_done for exactly the cycle after the wrap tick.
REQ-018 SHALL register hex and anodes; both reflect the new index one cycle after the tick, in the same cycle.
REQ-019 SHALL drive anodes = all ones except bit[index] = 0.
REQ-020 SHALL drive hex = {active_en[index] & show, active_nibble[index]}; show = 1 unless blanked per REQ-025.
REQ-021 SHALL keep hex[4] = 0 for a disabled digit while its anode is still driven low (decoder blanks segments).

Reset
REQ-022 SHALL, while rstn = 0, force prescaler = 0, index = 0, active/shadow value = 0, active/shadow enables = 0, pending = 0, frame_done = 0, hex = 5'b00000, anodes = 8'hFF.
REQ-023 SHALL drive anodes = 8'hFE and hex from digit 0 on the first rising edge after rstn deasserts.
REQ-024 SHALL discard a pending capture when reset asserts mid-frame.

Configuration
REQ-025 SHALL compile leading-zero blanking when LEADING_ZERO_BLANK_EN is defined: show = 0 for digit i (i >= 1) when active nibbles 7..i are all zero; digit 0 never blanked.
REQ-026 SHALL, when LEADING_ZERO_BLANK_EN is undefined, tie show = 1; only digit_en controls blanking.

Verification (REFRESH_DIV = 4)
REQ-027 SHALL cover reset: rstn low mid-scan -> anodes 8'hFF, hex 0, pending 0 at once; after release anodes 8'hFE, then 8'hFD 4 cycles later.
REQ-028 SHALL cover scan: load value 32'h89ABCDEF, digit_en 8'hFF, at wrap -> next frame hex = 5'h1F,5'h1E,...,5'h18 with anodes 8'hFE..8'h7F, each held 4 cycles, frame_done every 32 cycles.
REQ-029 SHALL cover tearing: load 32'h11111111 while index = 3 -> pending 1, hex unchanged until wrap, then all digits 5'h11, pending 0.
REQ-030 SHALL cover coincidence: load 32'h22222222 on the wrap tick -> pending never set, digit 0 shows 5'h12 next cycle.
REQ-031 SHALL cover enables: digit_en 8'h0F, value 32'h12345678 -> digits 4..7 hex[4] = 0 with anodes still cycling.
REQ-032 SHALL cover blanking: value 32'h00000305, digit_en 8'hFF -> with LEADING_ZERO_BLANK_EN digits 3..7 hex[4] = 0 and digit 1 shows 5'h10; without it all digits enabled.
